// File: rtl/ec_dmem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : ec_dmem_access_if
// Description : SRAM-like data bus (req / addr_ok / data_ok) between the EC
//               stage access controller and the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface ec_dmem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ec_dmem_access.sv
`default_nettype none
// ============================================================================
// Module      : ec_dmem_access
// Description : EC-stage data-memory access controller: issues one load/store
//               at a time, stalls until it completes, extends load results.
// Revision    : 1.0 - initial release
// ============================================================================
module ec_dmem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    input  wire logic              ec_data_req,
    input  wire logic              ec_load,
    input  wire logic              ec_loadX,
    input  wire logic [3:0]        ec_lsV,
    input  wire logic [ADDR_W-1:0] ec_res,
    input  wire logic [DATA_W-1:0] ec_B,
    input  wire logic              ec_exc,
    input  wire logic              refresh,
    input  wire logic              stall_in,
    ec_dmem_access_if.master       bus,
    output logic                   ec_stall,
    output logic                   ld_valid,
    output logic [DATA_W-1:0]      ld_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_kill;
    logic                w_kill_nxt;
    logic                r_load;
    logic                r_loadx;
    logic [3:0]          r_lsv;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_ld_buf;

    logic                w_start;
    logic                w_live;
    logic                w_load;
    logic [3:0]          w_lsv;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_b;
    logic [1:0]          w_size;
    logic [1:0]          w_rsize;
    logic [DATA_W-1:0]   w_rsh;
    logic [DATA_W-1:0]   w_ext;
    logic                w_kill_eff;
    logic                w_resp_ok;

    // resetn gates start so no output can rise while reset is held
    assign w_start = resetn & ec_data_req & ~ec_exc & ~refresh & (r_state == S_IDLE);

    // In IDLE the request is driven straight from EC; afterwards from the latch
    assign w_live = (r_state == S_IDLE);
    assign w_load = w_live ? ec_load : r_load;
    assign w_lsv  = w_live ? ec_lsV  : r_lsv;
    assign w_addr = w_live ? ec_res  : r_addr;
    assign w_b    = w_live ? ec_B    : r_b;

    function automatic logic [1:0] f_size(input logic [3:0] lsv);
        case (lsv)
            4'b1111:         f_size = 2'd2;
            4'b0011, 4'b1100: f_size = 2'd1;
            default:         f_size = 2'd0;
        endcase
    endfunction

    assign w_size  = f_size(w_lsv);
    assign w_rsize = f_size(r_lsv);

    assign bus.data_req   = w_start | (r_state == S_REQ);
    assign bus.data_wr    = bus.data_req & ~w_load;
    assign bus.data_size  = bus.data_req ? w_size : 2'd0;
    assign bus.data_addr  = bus.data_req ? w_addr : '0;
    assign bus.data_wstrb = (bus.data_req & ~w_load) ? w_lsv : 4'd0;
    assign bus.data_wdata = bus.data_req ? (w_b << {w_addr[1:0], 3'b000}) : '0;

    assign w_rsh = bus.data_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = w_rsh;
        case (w_rsize)
            2'd0:    w_ext = {{24{~r_loadx & w_rsh[7]}},  w_rsh[7:0]};
            2'd1:    w_ext = {{16{~r_loadx & w_rsh[15]}}, w_rsh[15:0]};
            default: w_ext = w_rsh;
        endcase
    end

    // A refresh coinciding with data_ok kills that response directly
    assign w_kill_eff = r_kill | refresh;
    assign w_resp_ok  = (r_state == S_WAIT) & bus.data_data_ok & ~w_kill_eff;

    assign ld_valid = r_load & ((w_resp_ok & ~stall_in) | (r_state == S_HOLD));
    assign ld_data  = ld_valid ? ((r_state == S_HOLD) ? r_ld_buf : w_ext) : '0;
    assign ec_stall = w_start | (r_state == S_REQ)
                    | ((r_state == S_WAIT) & ~w_resp_ok) | r_kill;

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = bus.data_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                if (refresh)          w_kill_nxt  = 1'b1;
                if (bus.data_addr_ok) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (refresh) w_kill_nxt = 1'b1;
                if (bus.data_data_ok) begin
                    if (w_kill_eff) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else if (stall_in) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (~stall_in | refresh) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_kill   <= 1'b0;
            r_load   <= 1'b0;
            r_loadx  <= 1'b0;
            r_lsv    <= 4'd0;
            r_addr   <= '0;
            r_b      <= '0;
            r_ld_buf <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            if (w_start) begin
                r_load  <= ec_load;
                r_loadx <= ec_loadX;
                r_lsv   <= ec_lsV;
                r_addr  <= ec_res;
                r_b     <= ec_B;
            end
            if (w_resp_ok & stall_in) begin
                r_ld_buf <= w_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ec_dmem_access.md
Name: ec_dmem_access

Overview:
- EC-stage data-memory access controller. Sits directly downstream of the EX/EC pipeline register.
- Consumes the registered load/store fields of the instruction in EC and drives an SRAM-like data bus (req / addr_ok / data_ok).
- Produces the aligned, extended load result for the writeback path.
- Asserts a stall until the access completes, and drains accesses killed by a pipeline refresh.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ec_data_req  in  1  EC instruction needs a memory access
- ec_load  in  1  1 = load, 0 = store
- ec_loadX  in  1  load is zero-extending (LBU/LHU)
- ec_lsV  in  4  byte-lane mask at word granularity: 0001/0010/0100/1000, 0011/1100, 1111
- ec_res  in  32  effective address
- ec_B  in  32  store data, unshifted
- ec_exc  in  1  EC instruction carries any exception (OR of ec_ex)
- refresh  in  1  pipeline flush
- stall_in  in  1  stall from later stages
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  request address
- data_wstrb  out  4  write strobes
- data_wdata  out  32  lane-aligned write data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data
- ec_stall  out  1  EC access not finished; stalls IF..EC
- ld_valid  out  1  ld_data valid this cycle
- ld_data  out  32  extended load result

Behaviour:
- Reset (async, resetn=0): state IDLE, kill=0, all latched fields 0. All outputs 0, including data_req, ec_stall and ld_valid. Reset mid-transaction abandons it; the bus is reset together with the core.
- start = ec_data_req & ~ec_exc & ~refresh, evaluated only in IDLE.
- State machine: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - On start: request fields are latched and data_req=1 in the same cycle, driven from the live inputs.
  - If addr_ok is seen that cycle, go to WAIT; otherwise go to REQ.
- REQ:
  - data_req=1 with the latched fields, which stay stable until addr_ok.
  - The request is never withdrawn, even on refresh.
  - On addr_ok, go to WAIT.
- WAIT: data_req=0.
  - On data_ok with kill=0 and stall_in=0: ld_valid=1 for one cycle (load only), ld_data taken combinationally from data_rdata, go to IDLE.
  - On data_ok with kill=0 and stall_in=1: capture ld_data into the buffer, go to HOLD.
  - On data_ok with kill=1: discard, clear kill, go to IDLE.
- HOLD: ld_valid=1 (load only) from the buffer. Go to IDLE when stall_in=0.
- kill:
  - Set by refresh while in REQ or WAIT; sticky until the matching data_ok.
  - refresh in IDLE or HOLD: HOLD goes to IDLE; nothing issues.
- ec_stall = start | REQ | (WAIT & ~(data_ok & ~kill)) | kill.
  - HOLD does not assert ec_stall.
  - At most one outstanding transaction.
- Sizing and strobes:
  - data_size = popcount(lsV): 1 gives 0, 2 gives 1, 4 gives 2.
  - data_wstrb = lsV for stores, 0 for loads.
  - data_wdata = B << 8*addr[1:0].
  - data_addr = ec_res unmodified.
  - Misaligned accesses never reach this block; they arrive flagged in ec_exc.
- Load extraction:
  - Shift r = rdata >> 8*addr[1:0].
  - Byte: loadX ? {24'b0, r[7:0]} : sign-extend r[7:0].
  - Half: same rule on r[15:0].
  - Word: r.
- Stores: complete on data_ok with ld_valid=0.
- Simultaneous refresh and data_ok in WAIT: the response is discarded and kill is not left set.

Test Plan:
- LB at addr 0x80000003, rdata=0x80AA5511, addr_ok same cycle, data_ok after 2 cycles -> data_req high 1 cycle, size=0; ec_stall high 3 cycles; ld_valid=1 with ld_data=0xFFFFFF80.
- LHU at 0x...2, rdata=0x8001FFFF -> ld_data=0x00008001. LW with addr_ok delayed 3 cycles -> data_req and data_addr held stable 4 cycles.
- SB at 0x...1, B=0x000000A5 -> data_wr=1, wstrb=0010, wdata=0x0000A500, size=0; ld_valid stays 0.
- Load in WAIT, refresh pulse, data_ok 2 cycles later with rdata=0x1234 -> ld_valid stays 0; ec_stall held until data_ok; new load issues the cycle after.
- data_ok while stall_in=1 for 3 cycles -> HOLD, ld_valid=1 with constant ld_data for 3 cycles, ec_stall=0, no re-issue; then IDLE.
- ec_exc=1 with ec_data_req=1 -> no data_req, ec_stall=0. resetn low during REQ -> all outputs 0 immediately (asynchronously).
